// File: rtl/serial_paralelo_rx_if.sv
// Serial RX link bundle: serial bit in, recovered byte/valid/active out.
// slave = deserializer side, master = bit source / byte consumer side.
interface serial_paralelo_rx_if;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  modport master (
    output data_in,
    input  data_out,
    input  valid_out,
    input  active
  );

  modport slave (
    input  data_in,
    output data_out,
    output valid_out,
    output active
  );
endinterface

// File: rtl/serial_paralelo_rx.sv
// RX serial-to-parallel converter with COM-symbol byte alignment and link-up detect.
// Ports: clk_32f bit clock, rst_L sync active-low reset, rx (slave) serial in / byte out.
module serial_paralelo_rx #(
  parameter logic [7:0]  COM        = 8'hBC,
  parameter int unsigned ACTIVE_CNT = 4
) (
  input  logic                 clk_32f,
  input  logic                 rst_L,
  serial_paralelo_rx_if.slave  rx
);

  localparam logic [3:0] LP_ACT = 4'(ACTIVE_CNT);

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_ALIGNED,
    ST_ACTIVE
  } state_t;

  state_t     r_state;
  logic [7:0] r_sr;
  logic [2:0] r_bit_cnt;
  logic [3:0] r_bc_cnt;
  logic [7:0] r_data_out;
  logic       r_valid_out;
  logic       r_active;

  logic [7:0] w_sr_next;
  logic       w_is_com;
  logic       w_boundary;
  logic       w_bc_full;
  logic [3:0] w_bc_inc;
  logic       w_lock_hit;

  assign w_sr_next  = {r_sr[6:0], rx.data_in};
  assign w_is_com   = (w_sr_next == COM);
  assign w_boundary = (r_bit_cnt == 3'd7);
  assign w_bc_full  = (r_bc_cnt >= LP_ACT);

  // COM count saturates at the link-up threshold
  assign w_bc_inc = w_bc_full ? r_bc_cnt
                              : r_bc_cnt + 4'd1;

  // Next aligned COM completes the required run
  assign w_lock_hit = (r_bc_cnt + 4'd1 == LP_ACT);

  always_ff @(posedge clk_32f) begin
    if (!rst_L) begin
      r_state     <= ST_SEARCH;
      r_sr        <= 8'h00;
      r_bit_cnt   <= 3'd0;
      r_bc_cnt    <= 4'd0;
      r_data_out  <= 8'h00;
      r_valid_out <= 1'b0;
      r_active    <= 1'b0;
    end else begin
      r_sr <= w_sr_next;
      unique case (r_state)
        ST_SEARCH: begin
          // Bit-by-bit hunt; the match edge defines the byte grid
          if (w_is_com) begin
            r_bit_cnt <= 3'd0;
            r_bc_cnt  <= 4'd1;
            if (LP_ACT == 4'd1) begin
              r_state  <= ST_ACTIVE;
              r_active <= 1'b1;
            end else begin
              r_state <= ST_ALIGNED;
            end
          end
        end
        ST_ALIGNED: begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (w_boundary) begin
            if (w_is_com) begin
              r_bc_cnt <= w_bc_inc;
              if (w_lock_hit) begin
                r_state  <= ST_ACTIVE;
                r_active <= 1'b1;
              end
            end else begin
              // Broken COM run: drop alignment and hunt again
              r_bc_cnt <= 4'd0;
              r_state  <= ST_SEARCH;
            end
          end
        end
        ST_ACTIVE: begin
          // Link stays up until reset; only grid-aligned bytes count
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (w_boundary) begin
            r_data_out  <= w_sr_next;
            r_valid_out <= !w_is_com;
            if (w_is_com) begin
              r_bc_cnt <= w_bc_inc;
            end
          end
        end
        default: begin
          r_state <= ST_SEARCH;
        end
      endcase
    end
  end

  assign rx.data_out  = r_data_out;
  assign rx.valid_out = r_valid_out;
  assign rx.active    = r_active;

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Bench for serial_paralelo_rx: directed lock/data/reset sequences,
// a byte vector table, and random streams against a reference model.
module tb_serial_paralelo_rx;

  localparam logic [7:0] COM = 8'hBC;
  localparam int         ACT = 4;

  logic clk_32f = 1'b0;
  logic rst_L   = 1'b0;

  serial_paralelo_rx_if u_if ();

  serial_paralelo_rx #(
    .COM        (COM),
    .ACTIVE_CNT (ACT)
  ) dut (
    .clk_32f (clk_32f),
    .rst_L   (rst_L),
    .rx      (u_if.slave)
  );

  always #5 clk_32f = ~clk_32f;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_active;
  } vec_t;

  vec_t vecs [7];
  bit   bq [$];

  // reference model state
  logic [7:0] m_w;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_active;
  logic       m_locked;
  int         m_t;
  int         m_anchor;
  int         m_count;

  task automatic check(input string name, input logic [7:0] d,
                       input logic v, input logic a);
    n_chk++;
    if (u_if.data_out !== d || u_if.valid_out !== v ||
        u_if.active !== a) begin
      n_fail++;
      $display("FAIL %s @%0t: got data=%h valid=%b active=%b, want data=%h valid=%b active=%b",
               name, $time, u_if.data_out, u_if.valid_out,
               u_if.active, d, v, a);
    end
  endtask

  task automatic edge_step(input logic r, input logic b);
    rst_L        = r;
    u_if.data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) bq.push_back(b[i]);
  endtask

  // Byte grid is the first COM match position plus multiples of 8 bits.
  task automatic model_step(input logic r, input logic b);
    if (!r) begin
      m_w = 8'h00; m_data = 8'h00; m_valid = 1'b0;
      m_active = 1'b0; m_locked = 1'b0;
      m_t = 0; m_anchor = 0; m_count = 0;
    end else begin
      m_t++;
      m_w = {m_w[6:0], b};
      if (!m_locked) begin
        if (m_w == COM) begin
          m_locked = 1'b1;
          m_anchor = m_t;
          m_count  = 1;
          if (m_count >= ACT) m_active = 1'b1;
        end
      end else if ((m_t - m_anchor) % 8 == 0) begin
        if (m_active) begin
          m_data  = m_w;
          m_valid = (m_w != COM);
        end else if (m_w == COM) begin
          m_count++;
          if (m_count >= ACT) m_active = 1'b1;
        end else begin
          m_locked = 1'b0;
        end
      end
    end
  endtask

  initial begin
    logic [7:0] pd;
    logic       pv;
    logic       pa;
    logic       r;
    logic       b;

    u_if.data_in = 1'b0;

    vecs[0] = '{8'hA5, 8'hA5, 1'b1, 1'b1};
    vecs[1] = '{8'h3C, 8'h3C, 1'b1, 1'b1};
    vecs[2] = '{8'hBC, 8'hBC, 1'b0, 1'b1};
    vecs[3] = '{8'h0B, 8'h0B, 1'b1, 1'b1};
    vecs[4] = '{8'hC0, 8'hC0, 1'b1, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 1'b1};
    vecs[6] = '{8'hBC, 8'hBC, 1'b0, 1'b1};

    // reset with random serial input
    for (int i = 0; i < 4; i++) begin
      edge_step(1'b0, 1'($urandom));
      check("reset", 8'h00, 1'b0, 1'b0);
    end

    // misaligned lock: 3 junk bits then 4 COMs
    bq = {};
    bq.push_back(1'b1);
    bq.push_back(1'b0);
    bq.push_back(1'b1);
    repeat (4) push_byte(COM);
    for (int e = 1; e <= bq.size(); e++) begin
      edge_step(1'b1, bq[e-1]);
      check("lock", 8'h00, 1'b0, logic'(e >= 35));
    end

    // byte table after lock (includes false COM across 0B/C0)
    pd = 8'h00; pv = 1'b0; pa = 1'b1;
    for (int k = 0; k < 7; k++) begin
      for (int i = 7; i >= 0; i--) begin
        edge_step(1'b1, vecs[k].din[i]);
        if (i != 0) check("table_hold", pd, pv, pa);
        else check("table_byte", vecs[k].exp_data,
                   vecs[k].exp_valid, vecs[k].exp_active);
      end
      pd = vecs[k].exp_data;
      pv = vecs[k].exp_valid;
      pa = vecs[k].exp_active;
    end

    // broken COM run
    edge_step(1'b0, 1'b0);
    check("broken_rst", 8'h00, 1'b0, 1'b0);
    bq = {};
    push_byte(COM);
    push_byte(COM);
    push_byte(8'h00);
    repeat (4) push_byte(COM);
    for (int e = 1; e <= bq.size(); e++) begin
      edge_step(1'b1, bq[e-1]);
      check("broken", 8'h00, 1'b0, logic'(e >= 56));
    end

    // reset in the middle of 0x5A while active
    edge_step(1'b1, 1'b0);
    check("mid_5a", 8'h00, 1'b0, 1'b1);
    edge_step(1'b1, 1'b1);
    check("mid_5a", 8'h00, 1'b0, 1'b1);
    edge_step(1'b1, 1'b0);
    check("mid_5a", 8'h00, 1'b0, 1'b1);
    edge_step(1'b1, 1'b1);
    check("mid_5a", 8'h00, 1'b0, 1'b1);
    edge_step(1'b0, 1'b1);
    check("mid_rst", 8'h00, 1'b0, 1'b0);
    bq = {};
    bq.push_back(1'b0);
    bq.push_back(1'b1);
    bq.push_back(1'b0);
    repeat (4) push_byte(COM);
    for (int e = 1; e <= bq.size(); e++) begin
      edge_step(1'b1, bq[e-1]);
      check("relock", 8'h00, 1'b0, logic'(e >= 35));
    end

    // random streams vs model
    edge_step(1'b0, 1'b0);
    model_step(1'b0, 1'b0);
    check("rnd_rst", m_data, m_valid, m_active);
    bq = {};
    for (int n = 0; n < 4000; n++) begin
      if (bq.size() == 0) begin
        int sel;
        sel = int'($urandom_range(0, 99));
        if (sel < 3) bq.push_back(1'($urandom));
        else if (sel < 60) push_byte(COM);
        else push_byte(8'($urandom));
      end
      b = bq.pop_front();
      r = ($urandom_range(0, 399) != 0);
      edge_step(r, b);
      model_step(r, b);
      check("random", m_data, m_valid, m_active);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
